param_sync_fifo: RTL

Parametrised single-clock FIFO, the next generation of the fixed 32-bit top-level FIFO. Generalises data width and depth. Adds programmable almost-full/almost-empty watermarks, an occupancy count, and sticky error flags with explicit clear. Sits between a producer and a consumer in the same clock domain. Keeps the legacy handshake: write/read strobes, full/empty, 8-bit status, err_read/err_write.

---
 rtl/param_sync_fifo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with watermarks, occupancy count and sticky error flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module param_sync_fifo #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_write,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_read,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        status,
    output logic              err_read,
    output logic              err_write
);

    localparam int unsigned PTR_W = CNT_W - 1;

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AeCnt    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_read_q, err_read_d;
    logic             err_write_q, err_write_d;
    logic             wr_acc, rd_acc;
    logic [31:0]      cnt_ext;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_acc = read && !empty;
        wr_acc = write && (!full || rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A new error on the same edge as clear_err keeps the flag set.
    always_comb begin
        err_read_d  = err_read_q;
        err_write_d = err_write_q;
        if (read && !rd_acc) begin
            err_read_d = 1'b1;
        end else if (clear_err) begin
            err_read_d = 1'b0;
        end
        if (write && !wr_acc) begin
            err_write_d = 1'b1;
        end else if (clear_err) begin
            err_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_read_q  <= 1'b0;
            err_write_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_read_q  <= err_read_d;
            err_write_q <= err_write_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_write;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    always_comb begin
        data_read = '0;
        if (!empty) begin
            data_read = mem[rd_ptr_q];
        end
    end
`else
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= mem[rd_ptr_q];
        end
    end

    assign data_read = data_q;
`endif

    always_comb begin
        cnt_ext      = 32'(count_q);
        full         = (count_q == DepthCnt);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AfCnt);
        almost_empty = (count_q <= AeCnt);
        status       = (cnt_ext > 32'd255) ? 8'hFF : cnt_ext[7:0];
    end

    assign count     = count_q;
    assign err_read  = err_read_q;
    assign err_write = err_write_q;

endmodule
